// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the 3-stage core hazard controller: writeback selects,
// controller FSM states and the NOP control word loaded into D/X on a bubble.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC  = 2'd2;
    localparam logic [1:0] WB_SEL_CSR = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    // Bubble counter is wide enough for REDIRECT_BUBBLES up to 3
    localparam int unsigned BUB_W = 2;

    typedef struct packed {
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       mem_re;
        logic       mem_we;
        logic       branch;
        logic       jump;
        logic       imux_nop;
    } dx_ctrl_t;

    localparam dx_ctrl_t DX_CTRL_NOP = dx_ctrl_t'(8'b0000_0001);

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter with synchronous clear; clear wins over increment.
module perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the F/D -> X -> W pipeline: load-use stalls,
// redirect flushes, memory-wait freezes and two performance counters.
module pipe_hazard_ctrl #(
    parameter logic [1:0]  WB_SEL_MEM       = 2'd1,
    parameter int unsigned REDIRECT_BUBBLES = 1,
    parameter int unsigned CNT_W            = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic             rs1_used_d,
    input  logic             rs2_used_d,
    input  logic [4:0]       rd_x,
    input  logic             reg_we_x,
    input  logic [1:0]       wb_sel_x,
    input  logic             redirect_x,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic             pc_stall,
    output logic             fd_stall,
    output logic             fd_flush,
    output logic             dx_stall,
    output logic             dx_bubble,
    output logic             xw_stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state_o
);

    import pipe_hazard_ctrl_pkg::*;

    localparam logic [BUB_W-1:0] BUB_RELOAD = BUB_W'(REDIRECT_BUBBLES - 1);

    state_e           state_q;
    state_e           state_d;
    logic [BUB_W-1:0] bub_q;
    logic [BUB_W-1:0] bub_d;
    logic             load_use;
    logic             flushing;
    logic             flush_inc;

    // A pending bubble count makes MEM_WAIT resume as FLUSH once memory is ready
    always_comb begin
        load_use = reg_we_x && (wb_sel_x == WB_SEL_MEM) && (rd_x != 5'd0) &&
                   ((rs1_used_d && (rs1_d == rd_x)) || (rs2_used_d && (rs2_d == rd_x)));
        flushing = ((state_q == ST_FLUSH) || (state_q == ST_MEM_WAIT)) && (bub_q != '0);
    end

    always_comb begin
        pc_stall  = 1'b0;
        fd_stall  = 1'b0;
        fd_flush  = 1'b0;
        dx_stall  = 1'b0;
        dx_bubble = 1'b0;
        xw_stall  = 1'b0;
        flush_inc = 1'b0;
        state_d   = state_q;
        bub_d     = bub_q;
        if (rst) begin
            state_d = ST_RUN;
            bub_d   = '0;
        end else if (mem_busy) begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            dx_stall = 1'b1;
            xw_stall = 1'b1;
            state_d  = ST_MEM_WAIT;
        end else if (redirect_x) begin
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
            flush_inc = 1'b1;
            bub_d     = BUB_RELOAD;
            state_d   = (REDIRECT_BUBBLES > 1) ? ST_FLUSH : ST_RUN;
        end else if (flushing) begin
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
            bub_d     = bub_q - BUB_W'(1);
            state_d   = (bub_q == BUB_W'(1)) ? ST_RUN : ST_FLUSH;
        end else begin
            state_d = ST_RUN;
            bub_d   = '0;
            if (load_use) begin
                pc_stall  = 1'b1;
                fd_stall  = 1'b1;
                dx_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            bub_q   <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
        end
    end

    assign state_o = state_q;

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .inc_i (pc_stall),
        .cnt_o (stall_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned RB = 2;
    localparam int unsigned CW = 8;
    localparam int unsigned CMOD = 1 << CW;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs1_d, rs2_d, rd_x;
    logic          rs1_used_d, rs2_used_d, reg_we_x;
    logic [1:0]    wb_sel_x;
    logic          redirect_x, mem_busy, cnt_clr;
    logic          pc_stall, fd_stall, fd_flush, dx_stall, dx_bubble, xw_stall;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [1:0]    state_o;

    int n_vec = 0;
    int n_err = 0;

    // Model: remaining flush cycles, whether memory was busy last cycle, counters
    int m_bub   = 0;
    bit m_wait  = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REDIRECT_BUBBLES (RB),
        .CNT_W            (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rs1_d      (rs1_d),
        .rs2_d      (rs2_d),
        .rs1_used_d (rs1_used_d),
        .rs2_used_d (rs2_used_d),
        .rd_x       (rd_x),
        .reg_we_x   (reg_we_x),
        .wb_sel_x   (wb_sel_x),
        .redirect_x (redirect_x),
        .mem_busy   (mem_busy),
        .cnt_clr    (cnt_clr),
        .pc_stall   (pc_stall),
        .fd_stall   (fd_stall),
        .fd_flush   (fd_flush),
        .dx_stall   (dx_stall),
        .dx_bubble  (dx_bubble),
        .xw_stall   (xw_stall),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .state_o    (state_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_lu();
        return reg_we_x && (wb_sel_x == 2'd1) && (rd_x != 5'd0) &&
               ((rs1_used_d && (rs1_d == rd_x)) || (rs2_used_d && (rs2_d == rd_x)));
    endfunction

    // {pc_stall, fd_stall, fd_flush, dx_stall, dx_bubble, xw_stall}
    function automatic logic [5:0] model_ctl();
        if (rst)                       return 6'b000000;
        if (mem_busy)                  return 6'b110101;
        if (redirect_x || (m_bub > 0)) return 6'b001010;
        if (model_lu())                return 6'b110010;
        return 6'b000000;
    endfunction

    function automatic int model_state();
        if (m_wait)    return 2;
        if (m_bub > 0) return 1;
        return 0;
    endfunction

    // One clock: compare mid-cycle, then advance the model across the edge
    task automatic tick();
        logic [5:0] e;
        @(negedge clk);
        e = model_ctl();
        chk("ctl", 32'({pc_stall, fd_stall, fd_flush, dx_stall, dx_bubble, xw_stall}), 32'(e));
        chk("state_o", 32'(state_o), 32'(model_state()));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        @(posedge clk);
        if (rst) begin
            m_bub = 0; m_wait = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            if (cnt_clr) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                m_stall = (m_stall + int'(e[5])) % CMOD;
                if (!mem_busy && redirect_x) m_flush = (m_flush + 1) % CMOD;
            end
            if (!mem_busy) begin
                if (redirect_x)     m_bub = RB - 1;
                else if (m_bub > 0) m_bub = m_bub - 1;
            end
            m_wait = mem_busy;
        end
        #1;
    endtask

    task automatic quiet();
        rs1_d = 5'd0; rs2_d = 5'd0; rd_x = 5'd0;
        rs1_used_d = 1'b0; rs2_used_d = 1'b0; reg_we_x = 1'b0;
        wb_sel_x = 2'd0; redirect_x = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
    endtask

    initial begin
        quiet();
        rst = 1'b1; redirect_x = 1'b1; mem_busy = 1'b1;
        @(posedge clk); #1;
        repeat (3) tick();
        chk("rst_ctl", 32'({pc_stall, fd_stall, fd_flush, dx_stall, dx_bubble, xw_stall}), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);

        rst = 1'b0; redirect_x = 1'b0;
        #1 chk("busy_stalls", 32'({pc_stall, fd_stall, dx_stall, xw_stall}), 32'hF);
        tick();
        chk("busy_state", 32'(state_o), 32'd2);
        chk("busy_stall_cnt", 32'(stall_cnt), 32'd1);

        mem_busy = 1'b0; cnt_clr = 1'b1;
        tick();
        chk("clr_stall_cnt", 32'(stall_cnt), 32'd0);
        cnt_clr = 1'b0;

        // Load-use on rs1
        reg_we_x = 1'b1; wb_sel_x = 2'd1; rd_x = 5'd5; rs1_d = 5'd5; rs1_used_d = 1'b1;
        #1 chk("lu_ctl", 32'({pc_stall, fd_stall, fd_flush, dx_stall, dx_bubble, xw_stall}), 32'b110010);
        tick();
        reg_we_x = 1'b0;
        #1 chk("lu_one_cycle", 32'(pc_stall), 32'd0);
        tick();
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        reg_we_x = 1'b1; rd_x = 5'd0; rs1_d = 5'd0;
        #1 chk("lu_x0", 32'(pc_stall), 32'd0);
        tick();

        // Redirect with two flush cycles
        quiet(); redirect_x = 1'b1;
        #1 chk("redir_ctl", 32'({pc_stall, fd_flush, dx_bubble}), 32'b011);
        tick();
        chk("redir_state", 32'(state_o), 32'd1);
        chk("redir_flush_cnt", 32'(flush_cnt), 32'd1);
        redirect_x = 1'b0;
        #1 chk("redir_2nd_flush", 32'(fd_flush), 32'd1);
        tick();
        chk("redir_back_run", 32'(state_o), 32'd0);
        #1 chk("redir_done", 32'(fd_flush), 32'd0);

        // Redirect and load-use together
        redirect_x = 1'b1; reg_we_x = 1'b1; wb_sel_x = 2'd1; rd_x = 5'd5; rs1_d = 5'd5; rs1_used_d = 1'b1;
        #1 chk("redir_lu_ctl", 32'({pc_stall, fd_flush}), 32'b01);
        tick();
        chk("redir_lu_stall_cnt", 32'(stall_cnt), 32'd1);
        chk("redir_lu_flush_cnt", 32'(flush_cnt), 32'd2);
        quiet();
        tick();

        // Memory wait with a redirect held in X
        mem_busy = 1'b1; redirect_x = 1'b1;
        repeat (4) begin
            #1 chk("wait_no_flush", 32'({pc_stall, fd_flush}), 32'b10);
            tick();
        end
        chk("wait_stall_cnt", 32'(stall_cnt), 32'd5);
        chk("wait_flush_cnt", 32'(flush_cnt), 32'd2);
        mem_busy = 1'b0;
        #1 chk("wait_release_flush", 32'(fd_flush), 32'd1);
        tick();
        chk("wait_release_cnt", 32'(flush_cnt), 32'd3);
        redirect_x = 1'b0;
        tick();

        // Counter wrap, then clear racing an increment
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0; mem_busy = 1'b1;
        repeat (CMOD - 1) tick();
        chk("wrap_max", 32'(stall_cnt), 32'(CMOD - 1));
        tick();
        chk("wrap_zero", 32'(stall_cnt), 32'd0);
        cnt_clr = 1'b1;
        #1 chk("clr_with_stall", 32'(pc_stall), 32'd1);
        tick();
        chk("clr_stall_zero", 32'(stall_cnt), 32'd0);
        chk("clr_flush_zero", 32'(flush_cnt), 32'd0);
        quiet();
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            mem_busy   = ($urandom_range(0, 4) == 0);
            redirect_x = ($urandom_range(0, 5) == 0);
            cnt_clr    = ($urandom_range(0, 49) == 0);
            reg_we_x   = 1'($urandom);
            wb_sel_x   = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'($urandom);
            rd_x       = 5'($urandom_range(0, 3));
            rs1_d      = 5'($urandom_range(0, 3));
            rs2_d      = 5'($urandom_range(0, 3));
            rs1_used_d = 1'($urandom);
            rs2_used_d = 1'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard/sequencing controller for the 3-stage RISC-V core (F/D → X → W).
- Drives the stall, bubble and flush controls of the PC register and the F/D, D/X and X/W pipeline registers, including the D→X control register bank.
- Detects load-use hazards and taken-branch/jump redirects, and freezes the pipe on multi-cycle memory waits.
- Keeps two performance counters readable through the CSR path.

Parameters:
- WB_SEL_MEM, 2'd1, wb_sel encoding that marks a load (writeback from memory).
- REDIRECT_BUBBLES, 1, number of cycles F/D is flushed after a redirect; legal range 1..3.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- rs1_d  in  5  rs1 index of the instruction in D
- rs2_d  in  5  rs2 index of the instruction in D
- rs1_used_d  in  1  D instruction reads rs1
- rs2_used_d  in  1  D instruction reads rs2
- rd_x  in  5  rd index of the instruction in X
- reg_we_x  in  1  X instruction writes the register file
- wb_sel_x  in  2  X writeback select
- redirect_x  in  1  taken branch, jal or jalr resolved in X
- mem_busy  in  1  data/instruction memory not ready this cycle
- cnt_clr  in  1  clear both counters
- pc_stall  out  1  hold the PC
- fd_stall  out  1  hold the F/D register
- fd_flush  out  1  replace the F/D instruction with a NOP
- dx_stall  out  1  hold the D/X registers
- dx_bubble  out  1  load a NOP (all-zero controls, imux_nop=1) into D/X
- xw_stall  out  1  hold the X/W register
- stall_cnt  out  CNT_W  count of cycles with pc_stall=1
- flush_cnt  out  CNT_W  count of redirect events
- state_o  out  2  current FSM state (debug)

Behaviour:
- FSM states: RUN=0, FLUSH=1, MEM_WAIT=2. Reset state RUN.
- On reset all outputs are 0, both counters are 0, and the flush counter is 0. The internal bubble counter is 0.
- load_use = reg_we_x & (wb_sel_x==WB_SEL_MEM) & (rd_x!=0) & ((rs1_used_d & rs1_d==rd_x) | (rs2_used_d & rs2_d==rd_x)).
- All stall/flush outputs are combinational from the current state and current inputs (zero-cycle latency). Counters and state are registered.
- Priority, highest first: rst > mem_busy > redirect_x > load_use.
- mem_busy=1, any state:
  - pc_stall, fd_stall, dx_stall and xw_stall all 1; fd_flush and dx_bubble 0.
  - Next state is MEM_WAIT.
  - The remaining bubble count is preserved and the FSM resumes FLUSH afterwards if the count is nonzero.
  - A redirect_x present during the wait is not consumed. X is frozen, so the redirect is acted on in the first cycle with mem_busy=0.
- MEM_WAIT with mem_busy=0: behaves as RUN in the same cycle (no dead cycle).
- RUN/MEM_WAIT with redirect_x=1 (mem_busy=0):
  - fd_flush=1 and dx_bubble=1; no stall.
  - flush_cnt increments.
  - If REDIRECT_BUBBLES>1, load the bubble counter with REDIRECT_BUBBLES-1 and go to FLUSH; else go to RUN.
- FLUSH:
  - fd_flush=1 and dx_bubble=1. Decrement the bubble counter; go to RUN when it reaches 0.
  - load_use is ignored in FLUSH.
  - A new redirect_x in FLUSH reloads the counter and increments flush_cnt.
- RUN with load_use=1 and no redirect:
  - pc_stall=1, fd_stall=1, dx_bubble=1; dx_stall=0 and xw_stall=0.
  - Stay in RUN. The bubble removes the load from X next cycle, so the stall lasts exactly 1 cycle per load.
- A simultaneous redirect and load_use is treated as a redirect only; no stall is counted.
- stall_cnt increments in every cycle pc_stall=1.
- Counters wrap modulo 2^CNT_W.
- cnt_clr zeroes both counters and takes priority over an increment in the same cycle.
- Reset mid-FLUSH or mid-MEM_WAIT returns to RUN next edge with all outputs 0.

Decomposition:
- Shared core package holds:
  - WB_SEL encodings (WB_SEL_MEM etc.);
  - the FSM state encodings RUN/FLUSH/MEM_WAIT;
  - the NOP control constants used for dx_bubble.
- One natural sub-module: perf_counter (CNT_W-bit counter with inc and clr), instantiated twice.

Test Plan:
- Reset held 3 cycles with redirect_x=1, mem_busy=1 → all outputs 0, state_o=0, counters 0; after release, mem_busy=1 gives all four stalls =1 and state_o=2.
- Load-use: wb_sel_x=WB_SEL_MEM, reg_we_x=1, rd_x=5, rs1_d=5, rs1_used_d=1 → exactly 1 cycle of pc_stall=fd_stall=dx_bubble=1, stall_cnt=1. Repeat with rd_x=0 → no stall.
- Redirect with REDIRECT_BUBBLES=2 → fd_flush=1 for 2 consecutive cycles, state_o 0→1→0, flush_cnt=1.
- Redirect and load-use in the same cycle → fd_flush=1, pc_stall=0, stall_cnt unchanged, flush_cnt +1.
- mem_busy held 4 cycles with redirect_x=1 → 4 cycles of full stall, stall_cnt=4, no flush. On the cycle mem_busy drops, fd_flush=1 and flush_cnt=1.
- Preload stall_cnt to 2^CNT_W-1, then stall → wraps to 0. cnt_clr asserted together with a stall → both counters 0.
